min_key_sched: RTL and testbench

//  Sequential arbiter for 2**IDX_W requesters, each presenting a KEY_W-bit key (e.g. hit distance).

---
 rtl/min_sched_pkg.sv | 27 ++
 rtl/min_key_sched.sv | 110 +++++++++++
 tb/tb_min_key_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/min_sched_pkg.sv
// Shared types and helpers for the sequential min-key scheduler.
// Holds the FSM state encoding, requester-count helper and key-slice accessor.
package min_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    // Upper bounds for the generic key accessor; callers zero-extend into these widths.
    localparam int unsigned KEY_MAX_W   = 32;
    localparam int unsigned KEY_BUS_MAX = 4096;

    function automatic int unsigned num_req(input int unsigned idx_w);
        return 32'd1 << idx_w;
    endfunction

    function automatic logic [KEY_MAX_W-1:0] key_at(
        input logic [KEY_BUS_MAX-1:0] bus,
        input int unsigned            i,
        input int unsigned            key_w
    );
        return bus[i*key_w +: KEY_MAX_W];
    endfunction

endpackage

// File: rtl/min_key_sched.sv
// Sequential argmin arbiter: snapshots requests, scans one entry per clock and
// grants the smallest key (lowest index on ties) until the owner pulses done.
module min_key_sched
    import min_sched_pkg::*;
#(
    parameter  int IDX_W = 3,
    parameter  int KEY_W = 10,
    localparam int N     = int'(num_req(IDX_W))
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*KEY_W-1:0]   key_bus,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic [KEY_W-1:0]     gnt_key,
    output logic                 gnt_valid,
    output logic                 busy
);

    state_t             r_state;
    logic [N-1:0]       r_mask;
    logic [N*KEY_W-1:0] r_keys;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_best_idx;
    logic [KEY_W-1:0]   r_best_key;
    logic               r_have_best;

    logic [N-1:0]       r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [KEY_W-1:0]   r_gnt_key;
    logic               r_gnt_valid;
    logic               r_busy;

    logic [KEY_W-1:0]   w_key_cur;
    logic               w_take;

    // N:1 key mux over the snapshot, followed by the strict-less comparator.
    assign w_key_cur = KEY_W'(key_at(KEY_BUS_MAX'(r_keys), 32'(r_cnt), 32'(KEY_W)));
    assign w_take    = r_mask[r_cnt] && (!r_have_best || (w_key_cur < r_best_key));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_keys      <= '0;
            r_cnt       <= '0;
            r_best_idx  <= '0;
            r_best_key  <= '0;
            r_have_best <= 1'b0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_key   <= '0;
            r_gnt_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_mask      <= req;
                        r_keys      <= key_bus;
                        r_cnt       <= '0;
                        r_have_best <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_take) begin
                        r_best_idx  <= r_cnt;
                        r_best_key  <= w_key_cur;
                        r_have_best <= 1'b1;
                    end
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == IDX_W'(N-1)) begin
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // First GRANT cycle publishes the result; done only counts once the grant is visible.
                    if (!r_gnt_valid) begin
                        r_gnt       <= N'(1) << r_best_idx;
                        r_gnt_idx   <= r_best_idx;
                        r_gnt_key   <= r_best_key;
                        r_gnt_valid <= 1'b1;
                    end else if (done) begin
                        r_gnt       <= '0;
                        r_gnt_idx   <= '0;
                        r_gnt_key   <= '0;
                        r_gnt_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_key   = r_gnt_key;
    assign gnt_valid = r_gnt_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_min_key_sched.sv
// Scoreboard bench for min_key_sched (IDX_W=3, KEY_W=10): expected grants are
// pushed at capture time and popped when gnt_valid rises.
module tb_min_key_sched;

    localparam int IDX_W = 3;
    localparam int KEY_W = 10;
    localparam int N     = 8;
    localparam int LAT   = N + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [KEY_W-1:0] key;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*KEY_W-1:0] key_bus;
    logic               done;
    logic [N-1:0]       gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [KEY_W-1:0]   gnt_key;
    logic               gnt_valid;
    logic               busy;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    min_key_sched #(.IDX_W(IDX_W), .KEY_W(KEY_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .key_bus   (key_bus),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_key   (gnt_key),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference argmin: smallest key among requesters, lowest index on ties.
    function automatic exp_t model(input logic [N-1:0] r, input logic [N*KEY_W-1:0] kb);
        exp_t             e;
        logic             have;
        logic [KEY_W-1:0] k;
        e    = '0;
        have = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = kb[i*KEY_W +: KEY_W];
            if (r[i] && (!have || k < e.key)) begin
                e.idx = IDX_W'(i);
                e.key = k;
                have  = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic set_key(input int i, input int k);
        key_bus[i*KEY_W +: KEY_W] = KEY_W'(k);
    endtask

    task automatic randomize_inputs(input bit small_keys);
        req = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
            set_key(i, small_keys ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 1023)));
        end
    endtask

    // Counts rising edges until gnt_valid is seen; returns 99 if the bound expires.
    task automatic wait_grant(output int lat);
        lat = 99;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (gnt_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        key_bus = '0;
        done    = 1'b0;
        #22;
        total++;
        if ({gnt, gnt_idx, gnt_key, gnt_valid, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h want=0", {gnt, gnt_idx, gnt_key, gnt_valid, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_req busy=%0b gnt_valid=%0b want 0 0", busy, gnt_valid);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   lat;
        @(negedge clk);
        key_bus = '0;
        for (int i = 0; i < N; i++) set_key(i, 1000 - i);
        set_key(2, 300);
        set_key(5, 120);
        req = 8'b0010_0100;
        sb.push_back(model(req, key_bus));
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy got=%0b want=1", busy);
        end
        @(negedge clk);
        req = '0;
        wait_grant(lat);
        e = sb.pop_front();
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=%0d", lat, LAT);
        end
        total++;
        if (gnt !== 8'b0010_0000 || gnt_idx !== e.idx || gnt_idx !== 3'd5) begin
            bad++;
            $display("FAIL basic_grant gnt=%0h idx=%0d want gnt=20 idx=%0d", gnt, gnt_idx, e.idx);
        end
        total++;
        if (gnt_key !== e.key || gnt_key !== 10'd120) begin
            bad++;
            $display("FAIL basic_key got=%0d want=%0d", gnt_key, e.key);
        end
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        total++;
        if ({gnt, gnt_idx, gnt_key, gnt_valid, busy} !== '0) begin
            bad++;
            $display("FAIL basic_release got=%0h want=0", {gnt, gnt_idx, gnt_key, gnt_valid, busy});
        end
    endtask

    task automatic test_tie();
        exp_t e;
        int   lat;
        @(negedge clk);
        req = '1;
        for (int i = 0; i < N; i++) set_key(i, 77);
        for (int round = 0; round < 2; round++) begin
            sb.push_back(model(req, key_bus));
            @(posedge clk);
            wait_grant(lat);
            e = sb.pop_front();
            total++;
            if (lat !== LAT || gnt_idx !== e.idx || gnt_idx !== 3'd0 || gnt_key !== 10'd77 || gnt !== 8'h01) begin
                bad++;
                $display("FAIL tie_round%0d lat=%0d idx=%0d key=%0d gnt=%0h want lat=%0d idx=0 key=77 gnt=01",
                         round, lat, gnt_idx, gnt_key, gnt, LAT);
            end
            @(negedge clk);
            done = 1'b1;
            if (round == 1) req = '0;
            @(posedge clk);
            #1;
            total++;
            if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
                bad++;
                $display("FAIL tie_idle_gap%0d gnt_valid=%0b busy=%0b gnt=%0h want 0 0 0", round, gnt_valid, busy, gnt);
            end
            @(negedge clk);
            done = 1'b0;
        end
    endtask

    task automatic test_drop_req();
        exp_t e;
        int   lat;
        @(negedge clk);
        key_bus = '0;
        set_key(0, 1023);
        set_key(7, 0);
        req = 8'h81;
        sb.push_back(model(req, key_bus));
        @(posedge clk);
        @(negedge clk);
        req = 8'h01;
        set_key(7, 900);
        wait_grant(lat);
        e = sb.pop_front();
        total++;
        if (lat !== LAT || gnt_idx !== e.idx || gnt_key !== e.key || gnt !== 8'h80) begin
            bad++;
            $display("FAIL drop_req lat=%0d idx=%0d key=%0d gnt=%0h want lat=%0d idx=%0d key=%0d gnt=80",
                     lat, gnt_idx, gnt_key, gnt, LAT, e.idx, e.key);
        end
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic test_hold();
        exp_t e;
        int   lat;
        @(negedge clk);
        key_bus = '0;
        set_key(1, 500);
        set_key(3, 499);
        set_key(4, 600);
        req = 8'b0001_1010;
        sb.push_back(model(req, key_bus));
        @(posedge clk);
        wait_grant(lat);
        e = sb.pop_front();
        total++;
        if (lat !== LAT || gnt_idx !== e.idx || gnt_key !== e.key) begin
            bad++;
            $display("FAIL hold_grant lat=%0d idx=%0d key=%0d want lat=%0d idx=%0d key=%0d",
                     lat, gnt_idx, gnt_key, LAT, e.idx, e.key);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            randomize_inputs(1'b0);
            @(posedge clk);
            #1;
            total++;
            if (gnt_valid !== 1'b1 || gnt_idx !== e.idx || gnt_key !== e.key || gnt !== (N'(1) << e.idx)) begin
                bad++;
                $display("FAIL hold_stable c=%0d valid=%0b idx=%0d key=%0d want 1 idx=%0d key=%0d",
                         c, gnt_valid, gnt_idx, gnt_key, e.idx, e.key);
            end
        end
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(posedge clk);
        #1;
        done = 1'b0;
        total++;
        if ({gnt, gnt_idx, gnt_key, gnt_valid, busy} !== '0) begin
            bad++;
            $display("FAIL hold_release got=%0h want=0", {gnt, gnt_idx, gnt_key, gnt_valid, busy});
        end
    endtask

    task automatic test_async_reset();
        int lat;
        // Reset during SCAN.
        @(negedge clk);
        randomize_inputs(1'b0);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_scan_busy got=%0b want=1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, gnt_idx, gnt_key, gnt_valid, busy} !== '0) begin
            bad++;
            $display("FAIL rst_scan_async got=%0h want=0", {gnt, gnt_idx, gnt_key, gnt_valid, busy});
        end
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || gnt_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_stay_idle c=%0d busy=%0b gnt_valid=%0b want 0 0", c, busy, gnt_valid);
            end
        end
        // Reset during GRANT.
        @(negedge clk);
        randomize_inputs(1'b0);
        @(posedge clk);
        @(negedge clk);
        req = '0;
        wait_grant(lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL rst_grant_lat got=%0d want=%0d", lat, LAT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, gnt_idx, gnt_key, gnt_valid, busy} !== '0) begin
            bad++;
            $display("FAIL rst_grant_async got=%0h want=0", {gnt, gnt_idx, gnt_key, gnt_valid, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_done_ignored();
        exp_t e;
        int   lat;
        @(negedge clk);
        req  = '0;
        done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_in_idle busy=%0b gnt_valid=%0b want 0 0", busy, gnt_valid);
        end
        // Single requester holding the maximum key, done pulsed inside the scan window.
        @(negedge clk);
        key_bus = '0;
        set_key(6, 1023);
        req = 8'h40;
        sb.push_back(model(req, key_bus));
        @(posedge clk);
        lat = 99;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            done = (c == 3 || c == 6);
            @(posedge clk);
            #1;
            if (gnt_valid) begin
                lat = c;
                break;
            end
        end
        e = sb.pop_front();
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL done_scan_latency got=%0d want=%0d", lat, LAT);
        end
        total++;
        if (gnt_idx !== e.idx || gnt_key !== 10'd1023 || gnt !== 8'h40) begin
            bad++;
            $display("FAIL max_key_single idx=%0d key=%0d gnt=%0h want idx=%0d key=1023 gnt=40",
                     gnt_idx, gnt_key, gnt, e.idx);
        end
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        @(negedge clk);
        randomize_inputs(1'b0);
        for (int t = 0; t < 6; t++) begin
            sb.push_back(model(req, key_bus));
            @(posedge clk);
            wait_grant(lat);
            e = sb.pop_front();
            total++;
            if (lat !== LAT || gnt_idx !== e.idx || gnt_key !== e.key || gnt !== (N'(1) << e.idx)) begin
                bad++;
                $display("FAIL b2b_t%0d lat=%0d idx=%0d key=%0d gnt=%0h want lat=%0d idx=%0d key=%0d",
                         t, lat, gnt_idx, gnt_key, gnt, LAT, e.idx, e.key);
            end
            @(negedge clk);
            done = 1'b1;
            if (t < 5) randomize_inputs(t[0]);
            else req = '0;
            @(posedge clk);
            #1;
            total++;
            if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b_gap_t%0d gnt_valid=%0b busy=%0b want 0 0", t, gnt_valid, busy);
            end
            @(negedge clk);
            done = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_drop_req();
        test_hold();
        test_async_reset();
        test_done_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
